// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit sitting beside the E-stage ALU.
//
// Accepts one M-extension op from E. Most ops take XLEN cycles. Divide-by-zero and
// signed divide overflow are special cases that resolve in one cycle and then give
// a single DONE cycle. busy_o drives the control unit's ALU-busy input. result_o is
// valid in the cycle that done_o is high.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   - Defined: all four multiply ops use a single-cycle combinational product and
//     take the fast path.
//   - Undefined: multiplies are radix-2 shift-add over XLEN cycles, and no
//     multiplier is inferred.
//   Divides are always iterative.
//
// Ports:
//   clk_i      core clock
//   resetn_i   asynchronous active-low reset
//   start_i    E holds a valid M-extension op
//   funct3_i   op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_i      operand 1 (already forwarded)
//   rs2_i      operand 2 (already forwarded)
//   kill_i     abort the in-flight op (trap or redirect)
//   busy_o     stall request to the control unit (combinational)
//   done_o     result valid this cycle (registered)
//   result_o   result (registered)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sa_q, sa_d;        // operand 1 (dividend) was negative
    logic              sb_q, sb_d;        // operand 2 (divisor) was negative
    logic [XLEN-1:0]   hi_q, hi_d;        // product high half, or partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;        // multiplier/product low half, or dividend/quotient
    logic [XLEN-1:0]   b_q, b_d;          // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    // Operand decode in the accept cycle
    logic            signed_a_s, signed_b_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, fast_result_s;
    logic            div_zero_s, overflow_s, fast_s;

    // Iteration datapath
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0]   run_hi_s, run_lo_s, quo_fix_s, rem_fix_s, final_s;
    logic [2*XLEN-1:0] prod_fix_s;

    // Decode operand signedness and magnitudes; detect the single-cycle cases
    always_comb begin
        signed_a_s = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
        signed_b_s = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        a_neg_s    = signed_a_s & rs1_i[XLEN-1];
        b_neg_s    = signed_b_s & rs2_i[XLEN-1];
        // The most negative value negates to itself, which is the correct unsigned magnitude.
        a_mag_s    = a_neg_s ? (~rs1_i + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_i;
        b_mag_s    = b_neg_s ? (~rs2_i + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_i;
        div_zero_s = (rs2_i == {XLEN{1'b0}});
        overflow_s = ((funct3_i == 3'b100) || (funct3_i == 3'b110)) &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == {XLEN{1'b1}});
`ifdef MULDIV_FAST_MUL_EN
        fast_s     = funct3_i[2] ? (div_zero_s | overflow_s) : 1'b1;
`else
        fast_s     = funct3_i[2] & (div_zero_s | overflow_s);
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s, fast_prod_fix_s;

    // Single-cycle product of magnitudes, then sign fix
    always_comb begin
        fast_prod_s     = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
        fast_prod_fix_s = (a_neg_s ^ b_neg_s) ? (~fast_prod_s + {{(2*XLEN-1){1'b0}}, 1'b1})
                                              : fast_prod_s;
    end
`endif

    // Result of a fast-path op, registered straight from the accept cycle
    always_comb begin
        fast_result_s = {XLEN{1'b0}};
        if (funct3_i[2]) begin
            if (funct3_i[1]) begin
                // Remainder: divide by zero returns the dividend; overflow returns 0
                fast_result_s = div_zero_s ? rs1_i : {XLEN{1'b0}};
            end else begin
                // Quotient: divide by zero returns all ones; overflow returns the most negative value
                fast_result_s = div_zero_s ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            fast_result_s = (funct3_i[1:0] == 2'b00) ? fast_prod_fix_s[XLEN-1:0]
                                                     : fast_prod_fix_s[2*XLEN-1:XLEN];
`else
            fast_result_s = {XLEN{1'b0}};
`endif
        end
    end

    // One shift-add or restoring shift-subtract step, plus the final sign fix and result select
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_q, lo_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        if (funct3_q[2]) begin
            // A set top bit of the difference means it went negative, so the divisor does not fit
            run_hi_s = div_diff_s[XLEN] ? div_shift_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
            run_lo_s = {lo_q[XLEN-2:0], ~div_diff_s[XLEN]};
        end else begin
            run_hi_s = mul_sum_s[XLEN:1];
            run_lo_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
        prod_fix_s = (sa_q ^ sb_q) ? (~{run_hi_s, run_lo_s} + {{(2*XLEN-1){1'b0}}, 1'b1})
                                   : {run_hi_s, run_lo_s};
        quo_fix_s  = (sa_q ^ sb_q) ? (~run_lo_s + {{(XLEN-1){1'b0}}, 1'b1}) : run_lo_s;
        rem_fix_s  = sa_q ? (~run_hi_s + {{(XLEN-1){1'b0}}, 1'b1}) : run_hi_s;
        case (funct3_q)
            3'b000:                 final_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_s = quo_fix_s;
            default:                final_s = rem_fix_s;
        endcase
    end

    // Next-state and next-register computation for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    funct3_d = funct3_i;
                    sa_d     = a_neg_s;
                    sb_d     = b_neg_s;
                    b_d      = b_mag_s;
                    hi_d     = {XLEN{1'b0}};
                    lo_d     = a_mag_s;
                    if (fast_s) begin
                        state_d  = S_DONE;
                        cnt_d    = {CW{1'b0}};
                        result_d = fast_result_s;
                    end else begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(XLEN);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    hi_d  = run_hi_s;
                    lo_d  = run_lo_s;
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        result_d = final_s;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            funct3_q <= 3'b000;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // busy_o is combinational so that E stalls in the accept cycle itself
    assign busy_o   = ((state_q == S_IDLE) & start_i & ~kill_i) | ((state_q == S_RUN) & ~kill_i);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .start_i  (start),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .kill_i   (kill),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, count busy cycles, then check the DONE cycle and the cycle after it.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_busy);
        int busy_n;
        int guard;
        @(negedge clk);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        busy_n = 0;
        guard  = 0;
        #1;
        while (busy && guard < 100) begin
            busy_n++;
            guard++;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy_n), 32'(exp_busy));
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_res"}, result, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        resetn = 1'b0;
        start  = 1'b0;
        funct3 = 3'b000;
        rs1    = 32'd0;
        rs2    = 32'd0;
        kill   = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Multiplies
        run_op("mul_7_m3",   3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_BUSY);
        run_op("mulhu_ff",   3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, MUL_BUSY);
        run_op("mulh_ff",    3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, MUL_BUSY);
        run_op("mulhsu_ff",  3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, MUL_BUSY);
        run_op("mulhu_2p33", 3'b011, 32'h80000000,   32'd4,        32'h00000002, MUL_BUSY);

        // Iterative divides
        run_op("div_m7_2",   3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, DIV_BUSY);
        run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, DIV_BUSY);
        run_op("divu_100_7", 3'b101, 32'd100,        32'd7,        32'd14,       DIV_BUSY);
        run_op("remu_100_7", 3'b111, 32'd100,        32'd7,        32'd2,        DIV_BUSY);

        // Fast-path divides
        run_op("divu_5_0",   3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_5_0",    3'b110, 32'd5,          32'd0,        32'd5,        1);
        run_op("div_ovf",    3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);

        // start and kill together in IDLE: the op is ignored
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
        #1;
        check("startkill_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        #1;
        check("startkill_idle_busy", {31'd0, busy}, 32'd0);
        check("startkill_done", {31'd0, done}, 32'd0);

        // kill on RUN cycle 10 of a DIVU
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        #1;
        check("kill_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        #1;
        check("kill_after_busy", {31'd0, busy}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("kill_no_done", 32'(done_seen), 32'd0);
        run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, MUL_BUSY);

        // Reset asserted mid-RUN on a divide (always iterative)
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrun_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rstrun_busy", {31'd0, busy}, 32'd0);
        check("rstrun_done", {31'd0, done}, 32'd0);
        check("rstrun_result", result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("mul_7_m3_again", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_BUSY);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
